// File: rtl/dma_rd_arbiter.sv
// dma_rd_arbiter: round-robin sharing of the single DMA read port among
// NUM_REQ burst clients, one whole burst per grant.
//
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_req                per-client request level, held until its o_done
//   i_req_addr           per-client start address, client k at [k*AW +: AW]
//   i_req_len            per-client beat count, client k at [k*LW +: LW]
//   o_gnt                one-hot grant, high for the whole burst
//   o_rd_valid           per-client data strobe (o_gnt gated by a beat)
//   o_rd_data            DMA read data broadcast to all clients
//   o_done               one-cycle burst-complete pulse, one-hot
//   o_busy               arbiter is not idle
//   i_dma_rd_ready       DMA accepts a read this cycle
//   i_dma_rd_data        DMA data, valid in the same cycle as o_dma_rd_en
//   o_dma_rd_en          DMA read strobe
//   o_dma_rd_addr        DMA read address
module dma_rd_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int AW      = 6,
    parameter int DW      = 16,
    parameter int LW      = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_REQ-1:0]    i_req,
    input  logic [NUM_REQ*AW-1:0] i_req_addr,
    input  logic [NUM_REQ*LW-1:0] i_req_len,
    output logic [NUM_REQ-1:0]    o_gnt,
    output logic [NUM_REQ-1:0]    o_rd_valid,
    output logic [DW-1:0]         o_rd_data,
    output logic [NUM_REQ-1:0]    o_done,
    output logic                  o_busy,
    input  logic                  i_dma_rd_ready,
    input  logic [DW-1:0]         i_dma_rd_data,
    output logic                  o_dma_rd_en,
    output logic [AW-1:0]         o_dma_rd_addr
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [PW-1:0]        idx_q;
    logic [PW-1:0]        ptr_q;
    logic [AW-1:0]        addr_q;
    logic [LW-1:0]        rem_q;

    logic                 sel_vld;
    logic [PW-1:0]        sel_idx;
    logic [NUM_REQ-1:0]   sel_gnt;
    logic [AW-1:0]        sel_addr;
    logic [LW-1:0]        sel_len;
    logic                 beat;

    // Two passes give "first requester at or after ptr, wrapping":
    // the first pass only looks at k >= ptr, the second catches k < ptr.
    always_comb begin
        sel_vld  = 1'b0;
        sel_idx  = '0;
        sel_gnt  = '0;
        sel_addr = '0;
        sel_len  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!sel_vld && i_req[k] && (PW'(k) >= ptr_q)) begin
                sel_vld    = 1'b1;
                sel_idx    = PW'(k);
                sel_gnt    = '0;
                sel_gnt[k] = 1'b1;
                sel_addr   = i_req_addr[k*AW +: AW];
                sel_len    = i_req_len[k*LW +: LW];
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!sel_vld && i_req[k]) begin
                sel_vld    = 1'b1;
                sel_idx    = PW'(k);
                sel_gnt    = '0;
                sel_gnt[k] = 1'b1;
                sel_addr   = i_req_addr[k*AW +: AW];
                sel_len    = i_req_len[k*LW +: LW];
            end
        end
    end

    assign beat = (state_q == BURST) && i_dma_rd_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    state_d = (sel_len == '0) ? DONE : BURST;
                end
            end
            BURST: begin
                if (beat && (rem_q == LW'(1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            gnt_q  <= '0;
            idx_q  <= '0;
            ptr_q  <= '0;
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sel_vld) begin
                        gnt_q  <= sel_gnt;
                        idx_q  <= sel_idx;
                        addr_q <= sel_addr;
                        rem_q  <= sel_len;
                    end
                end
                BURST: begin
                    if (beat) begin
                        addr_q <= addr_q + 1'b1;
                        rem_q  <= rem_q - 1'b1;
                    end
                end
                DONE: begin
                    gnt_q <= '0;
                    ptr_q <= (idx_q == PW'(NUM_REQ - 1)) ? '0
                                                          : idx_q + 1'b1;
                end
                default: begin
                    gnt_q <= '0;
                end
            endcase
        end
    end

    assign o_gnt         = gnt_q;
    assign o_busy        = (state_q != IDLE);
    assign o_done        = (state_q == DONE) ? gnt_q : '0;
    assign o_dma_rd_en   = beat;
    assign o_dma_rd_addr = addr_q;
    assign o_rd_valid    = beat ? gnt_q : '0;
    assign o_rd_data     = i_dma_rd_data;

endmodule

// File: tb/tb_dma_rd_arbiter.sv
// Testbench for dma_rd_arbiter: scenario tasks checked against a
// burst-level reference model (round-robin pick, address/beat sequence).
module tb_dma_rd_arbiter;

    localparam int N   = 3;
    localparam int AW  = 6;
    localparam int DW  = 16;
    localparam int LW  = 8;
    localparam int AWT = N * AW;
    localparam int LWT = N * LW;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   i_req;
    logic [AWT-1:0] i_req_addr;
    logic [LWT-1:0] i_req_len;
    logic [N-1:0]   o_gnt;
    logic [N-1:0]   o_rd_valid;
    logic [DW-1:0]  o_rd_data;
    logic [N-1:0]   o_done;
    logic           o_busy;
    logic           i_dma_rd_ready;
    logic [DW-1:0]  i_dma_rd_data;
    logic           o_dma_rd_en;
    logic [AW-1:0]  o_dma_rd_addr;

    dma_rd_arbiter #(
        .NUM_REQ(N), .AW(AW), .DW(DW), .LW(LW)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_req          (i_req),
        .i_req_addr     (i_req_addr),
        .i_req_len      (i_req_len),
        .o_gnt          (o_gnt),
        .o_rd_valid     (o_rd_valid),
        .o_rd_data      (o_rd_data),
        .o_done         (o_done),
        .o_busy         (o_busy),
        .i_dma_rd_ready (i_dma_rd_ready),
        .i_dma_rd_data  (i_dma_rd_data),
        .o_dma_rd_en    (o_dma_rd_en),
        .o_dma_rd_addr  (o_dma_rd_addr)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: pending requests, per-client burst parameters,
    // round-robin pointer and the address register's expected value.
    logic [N-1:0]  req_v;
    logic [AW-1:0] addr_m [N];
    logic [LW-1:0] len_m  [N];
    int            ptr_m;
    logic [AW-1:0] last_addr;

    // bundle = {gnt, busy, rd_en, rd_addr, rd_valid, done}
    logic [16:0] got;
    logic [16:0] exp_b;

    function automatic int pick();
        for (int off = 0; off < N; off++) begin
            if (req_v[(ptr_m + off) % N]) return (ptr_m + off) % N;
        end
        return -1;
    endfunction

    task automatic drive_req();
        i_req = req_v;
        for (int c = 0; c < N; c++) begin
            i_req_addr[c*AW +: AW] = addr_m[c];
            i_req_len[c*LW +: LW]  = len_m[c];
        end
    endtask

    // Runs one burst starting from an IDLE cycle and checks every cycle
    // up to and including the DONE pulse.
    task automatic do_burst(input int stall_at, input bit rnd,
                            input bit oneshot);
        int k;
        int b;
        int n;
        logic [AW-1:0] la;
        logic [LW-1:0] ll;
        logic [N-1:0]  eg;
        logic          rdy;
        logic [DW-1:0] dat;
        @(posedge i_clk); #1;
        drive_req();
        i_dma_rd_ready = 1'b1;
        @(negedge i_clk);
        got   = {o_gnt, o_busy, o_dma_rd_en, o_dma_rd_addr,
                 o_rd_valid, o_done};
        exp_b = {3'b000, 1'b0, 1'b0, last_addr, 3'b000, 3'b000};
        n_tests++;
        if (got !== exp_b) begin
            n_fail++;
            $display("FAIL idle: got %h want %h", got, exp_b);
        end
        k = pick();
        if (k < 0) begin
            n_fail++;
            $display("FAIL pick: got none want a requester");
            return;
        end
        la = addr_m[k];
        ll = len_m[k];
        eg = N'(1) << k;
        b  = 0;
        n  = 0;
        while (b < int'(ll) && n < 200) begin
            @(posedge i_clk); #1;
            rdy = (n == stall_at) ? 1'b0 :
                  (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            dat = DW'($urandom);
            i_dma_rd_ready = rdy;
            i_dma_rd_data  = dat;
            if (rnd) begin
                i_req      = N'($urandom);
                i_req_addr = AWT'($urandom);
                i_req_len  = LWT'($urandom);
            end
            @(negedge i_clk);
            got   = {o_gnt, o_busy, o_dma_rd_en, o_dma_rd_addr,
                     o_rd_valid, o_done};
            exp_b = {eg, 1'b1, rdy, AW'(la + AW'(b)),
                     rdy ? eg : 3'b000, 3'b000};
            n_tests++;
            if (got !== exp_b) begin
                n_fail++;
                $display("FAIL beat%0d: got %h want %h", b, got, exp_b);
            end
            n_tests++;
            if (o_rd_data !== dat) begin
                n_fail++;
                $display("FAIL data: got %h want %h", o_rd_data, dat);
            end
            if (rdy) b++;
            n++;
        end
        if (n >= 200) begin
            n_fail++;
            $display("FAIL timeout: got %0d beats want %0d", b, ll);
        end
        last_addr = AW'(la + AW'(ll));
        @(posedge i_clk); #1;
        if (oneshot) req_v[k] = 1'b0;
        drive_req();
        i_dma_rd_ready = 1'b1;
        @(negedge i_clk);
        got   = {o_gnt, o_busy, o_dma_rd_en, o_dma_rd_addr,
                 o_rd_valid, o_done};
        exp_b = {eg, 1'b1, 1'b0, last_addr, 3'b000, eg};
        n_tests++;
        if (got !== exp_b) begin
            n_fail++;
            $display("FAIL done: got %h want %h", got, exp_b);
        end
        ptr_m = (k + 1) % N;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        req_v = 3'b111;
        for (int c = 0; c < N; c++) begin
            addr_m[c] = AW'(c + 1);
            len_m[c]  = 8'd2;
        end
        drive_req();
        i_dma_rd_ready = 1'b1;
        i_dma_rd_data  = '0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        got   = {o_gnt, o_busy, o_dma_rd_en, o_dma_rd_addr,
                 o_rd_valid, o_done};
        exp_b = '0;
        n_tests++;
        if (got !== exp_b) begin
            n_fail++;
            $display("FAIL reset: got %h want %h", got, exp_b);
        end
        req_v = '0;
        drive_req();
        @(posedge i_clk); #1;
        i_rst     = 1'b0;
        ptr_m     = 0;
        last_addr = '0;
    endtask

    task automatic test_single();
        req_v     = 3'b001;
        addr_m[0] = 6'd5;
        len_m[0]  = 8'd4;
        do_burst(-1, 1'b0, 1'b1);
    endtask

    task automatic test_round_robin();
        req_v = 3'b111;
        for (int c = 0; c < N; c++) begin
            addr_m[c] = AW'(16 * c + 3);
            len_m[c]  = 8'd2;
        end
        for (int i = 0; i < 6; i++) do_burst(-1, 1'b0, 1'b0);
        req_v = '0;
    endtask

    task automatic test_stall();
        req_v     = 3'b010;
        addr_m[1] = 6'd10;
        len_m[1]  = 8'd3;
        do_burst(1, 1'b0, 1'b1);
    endtask

    task automatic test_zero_len();
        req_v     = 3'b100;
        addr_m[2] = 6'd33;
        len_m[2]  = 8'd0;
        do_burst(-1, 1'b0, 1'b1);
        req_v     = 3'b101;
        addr_m[0] = 6'd20;
        len_m[0]  = 8'd1;
        do_burst(-1, 1'b0, 1'b1);
        do_burst(-1, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        req_v     = 3'b001;
        addr_m[0] = 6'd62;
        len_m[0]  = 8'd4;
        do_burst(-1, 1'b0, 1'b1);
    endtask

    task automatic test_mid_reset();
        logic [AW-1:0] a0;
        a0        = AW'($urandom);
        req_v     = 3'b001;
        addr_m[0] = a0;
        len_m[0]  = 8'd5;
        @(posedge i_clk); #1;
        drive_req();
        i_dma_rd_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge i_clk); #1;
            @(negedge i_clk);
            got   = {o_gnt, o_busy, o_dma_rd_en, o_dma_rd_addr,
                     o_rd_valid, o_done};
            exp_b = {3'b001, 1'b1, 1'b1, AW'(a0 + AW'(i)),
                     3'b001, 3'b000};
            n_tests++;
            if (got !== exp_b) begin
                n_fail++;
                $display("FAIL prerst%0d: got %h want %h", i, got, exp_b);
            end
        end
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        req_v = '0;
        drive_req();
        #1;
        got   = {o_gnt, o_busy, o_dma_rd_en, o_dma_rd_addr,
                 o_rd_valid, o_done};
        exp_b = '0;
        n_tests++;
        if (got !== exp_b) begin
            n_fail++;
            $display("FAIL midrst: got %h want %h", got, exp_b);
        end
        @(posedge i_clk); #1;
        i_rst     = 1'b0;
        ptr_m     = 0;
        last_addr = '0;
        req_v     = 3'b001;
        addr_m[0] = AW'($urandom);
        len_m[0]  = 8'd5;
        do_burst(-1, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < N; c++) begin
                addr_m[c] = AW'($urandom);
                len_m[c]  = LW'($urandom_range(0, 7));
                if ($urandom_range(0, 2) == 0) req_v[c] = 1'b1;
            end
            if (req_v == '0) req_v[$urandom_range(0, N - 1)] = 1'b1;
            do_burst(-1, 1'b1, 1'($urandom_range(0, 1)));
        end
        req_v = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_zero_len();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
